aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 179 +++++++++++++++++
 tb/tb_aes_iter_core.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryption core with on-the-fly key expansion.
// UNROLL (1, 2, 5 or 10) sets how many rounds are evaluated per clock.
// Optional build macro AES_LAST_KEY_OUT_EN adds output last_round_key, the
// round-10 key captured with the cyphertext, for a downstream decryption block.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// RUN   | UNROLL rounds applied per cycle; inputs ignored; busy high
// DONE  | cyphertext held with out_valid until out_ready
module aes_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cyphertext,
  output logic         busy
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [127:0] last_round_key
`endif
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q;
  logic [127:0] st_q;
  logic [127:0] rk_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;

  logic [127:0] s_nx;
  logic [127:0] k_nx;
  logic [7:0]   rc_nx;
  logic         accept;
  logic         last_step;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte 4*c+r is row r of column c; byte 0 sits at [127:120].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last_step = (({1'b0, round_q} + 5'(UNROLL)) == 5'd11);

  // Chain of UNROLL rounds starting at round_q; the key schedule advances in step.
  always_comb begin
    s_nx  = st_q;
    k_nx  = rk_q;
    rc_nx = rcon_q;
    for (int u = 0; u < UNROLL; u++) begin
      k_nx  = next_key(k_nx, rc_nx);
      rc_nx = xtime(rc_nx);
      s_nx  = sub_shift(s_nx);
      if (({1'b0, round_q} + 5'(u)) != 5'd10) s_nx = mix_columns(s_nx);
      s_nx  = s_nx ^ k_nx;
    end
  end

  // Control FSM and datapath registers; an accept from DONE consumes the old result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      st_q           <= '0;
      rk_q           <= '0;
      rcon_q         <= '0;
      round_q        <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      cyphertext     <= '0;
`ifdef AES_LAST_KEY_OUT_EN
      last_round_key <= '0;
`endif
    end else if (accept) begin
      st_q      <= plaintext ^ key;
      rk_q      <= key;
      rcon_q    <= 8'h01;
      round_q   <= 4'd1;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      state_q   <= RUN;
    end else if (state_q == RUN) begin
      st_q   <= s_nx;
      rk_q   <= k_nx;
      rcon_q <= rc_nx;
      if (last_step) begin
        cyphertext     <= s_nx;
`ifdef AES_LAST_KEY_OUT_EN
        last_round_key <= k_nx;
`endif
        out_valid      <= 1'b1;
        busy           <= 1'b0;
        round_q        <= 4'd0;
        state_q        <= DONE;
      end else begin
        round_q <= round_q + 4'(UNROLL);
      end
    end else if ((state_q == DONE) && out_ready) begin
      out_valid <= 1'b0;
      state_q   <= IDLE;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Testbench for aes_iter_core: UNROLL=1 main instance plus UNROLL=2/5/10 instances.
module tb_aes_iter_core;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] L1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] L2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] key, plaintext, cyphertext, lrk;

  logic         u_in_valid [3];
  logic         u_in_ready [3];
  logic         u_out_valid[3];
  logic         u_out_ready[3];
  logic         u_busy     [3];
  logic [127:0] u_ct       [3];
  logic [127:0] u_lrk      [3];
  logic [127:0] u_key, u_pt;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] expk_q[$];

  always #5 clk = ~clk;

  aes_iter_core #(.UNROLL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .plaintext(plaintext), .out_valid(out_valid), .out_ready(out_ready),
    .cyphertext(cyphertext), .busy(busy)
`ifdef AES_LAST_KEY_OUT_EN
    , .last_round_key(lrk)
`endif
  );

  for (genvar g = 0; g < 3; g++) begin : g_unr
    localparam int UV = (g == 0) ? 2 : ((g == 1) ? 5 : 10);
    aes_iter_core #(.UNROLL(UV)) u_dut (
      .clk(clk), .reset(reset), .in_valid(u_in_valid[g]), .in_ready(u_in_ready[g]),
      .key(u_key), .plaintext(u_pt), .out_valid(u_out_valid[g]), .out_ready(u_out_ready[g]),
      .cyphertext(u_ct[g]), .busy(u_busy[g])
`ifdef AES_LAST_KEY_OUT_EN
      , .last_round_key(u_lrk[g])
`endif
    );
  end

`ifndef AES_LAST_KEY_OUT_EN
  assign lrk = '0;
  always_comb for (int i = 0; i < 3; i++) u_lrk[i] = '0;
`endif

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0; plaintext = '0;
    u_key = '0; u_pt = '0;
    for (int g = 0; g < 3; g++) begin u_in_valid[g] = 1'b0; u_out_ready[g] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cyphertext !== 128'h0) begin errors++; $display("FAIL reset_cyphertext got %h want 0", cyphertext); end
`ifdef AES_LAST_KEY_OUT_EN
    checks++; if (lrk !== 128'h0) begin errors++; $display("FAIL reset_last_key got %h want 0", lrk); end
`endif
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (u_out_valid[g] !== 1'b0 || u_in_ready[g] !== 1'b1) begin
        errors++; $display("FAIL reset_unroll_inst%0d got ov=%b ir=%b want ov=0 ir=1", g, u_out_valid[g], u_in_ready[g]);
      end
    end
  endtask

  // Releases reset and accepts on the very first posedge afterwards.
  task automatic test_vector_unroll1();
    int lat;
    logic [127:0] e, ek;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; key = K1; plaintext = P1; out_ready = 1'b0;
    exp_q.push_back(C1); expk_q.push_back(L1);
    @(posedge clk); #1;
    in_valid = 1'b0; key = '0; plaintext = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_accept busy got %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 10) begin errors++; $display("FAIL u1_latency got %0d want 10", lat); end
    e = exp_q.pop_front(); ek = expk_q.pop_front();
    checks++; if (cyphertext !== e) begin errors++; $display("FAIL u1_cyphertext got %h want %h", cyphertext, e); end
`ifdef AES_LAST_KEY_OUT_EN
    checks++; if (lrk !== ek) begin errors++; $display("FAIL u1_last_key got %h want %h", lrk, ek); end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cyphertext !== e) begin
      errors++; $display("FAIL u1_consume got ov=%b ir=%b ct=%h want ov=0 ir=1 ct=%h", out_valid, in_ready, cyphertext, e);
    end
  endtask

  task automatic test_unroll();
    int lat[3];
    int want[3];
    logic [127:0] e, ek;
    want[0] = 5; want[1] = 2; want[2] = 1;
    @(negedge clk);
    u_key = K2; u_pt = P2;
    for (int g = 0; g < 3; g++) begin
      lat[g] = 0; u_in_valid[g] = 1'b1; u_out_ready[g] = 1'b1;
      exp_q.push_back(C2); expk_q.push_back(L2);
      checks++; if (u_in_ready[g] !== 1'b1) begin errors++; $display("FAIL unroll_ready_inst%0d got %b want 1", g, u_in_ready[g]); end
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      u_in_valid[g] = 1'b0;
      checks++; if (u_busy[g] !== 1'b1) begin errors++; $display("FAIL unroll_busy_inst%0d got %b want 1", g, u_busy[g]); end
    end
    u_key = '0; u_pt = '0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        if (u_out_valid[g]) begin
          if (lat[g] == 0) lat[g] = c;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL unroll_extra_output_inst%0d got output want none", g);
          end else begin
            e = exp_q.pop_front(); ek = expk_q.pop_front();
            if (u_ct[g] !== e) begin errors++; $display("FAIL unroll_ct_inst%0d got %h want %h", g, u_ct[g], e); end
`ifdef AES_LAST_KEY_OUT_EN
            checks++; if (u_lrk[g] !== ek) begin errors++; $display("FAIL unroll_key_inst%0d got %h want %h", g, u_lrk[g], ek); end
`endif
          end
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      u_out_ready[g] = 1'b0;
      checks++; if (lat[g] !== want[g]) begin errors++; $display("FAIL unroll_latency_inst%0d got %0d want %0d", g, lat[g], want[g]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] e;
    @(negedge clk);
    in_valid = 1'b1; key = K2; plaintext = P2; out_ready = 1'b0;
    exp_q.push_back(C2); expk_q.push_back(L2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 10) begin errors++; $display("FAIL bp_latency got %0d want 10", lat); end
    e = exp_q.pop_front(); void'(expk_q.pop_front());
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || cyphertext !== e || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold got ov=%b ir=%b ct=%h want ov=1 ir=0 ct=%h", out_valid, in_ready, cyphertext, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b busy=%b ir=%b want ov=0 busy=0 ir=1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int c, nseen, t1, t2;
    logic [127:0] e;
    @(negedge clk);
    in_valid = 1'b1; key = K1; plaintext = P1; out_ready = 1'b1;
    exp_q.push_back(C1); exp_q.push_back(C2);
    @(posedge clk); #1;
    key = K2; plaintext = P2;
    c = 0; nseen = 0; t1 = 0; t2 = 0;
    while (nseen < 2 && c < 60) begin
      @(posedge clk); #1; c++;
      if (nseen == 1 && c == t1 + 1) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_same_edge got busy=%b ov=%b want busy=1 ov=0", busy, out_valid);
        end
        in_valid = 1'b0;
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_output got output want none");
        end else begin
          e = exp_q.pop_front();
          if (cyphertext !== e) begin errors++; $display("FAIL b2b_ct%0d got %h want %h", nseen, cyphertext, e); end
        end
        nseen++;
        if (nseen == 1) t1 = c; else t2 = c;
      end
    end
    checks++; if (t1 !== 10) begin errors++; $display("FAIL b2b_first_time got %0d want 10", t1); end
    checks++; if (t2 !== 21) begin errors++; $display("FAIL b2b_second_time got %0d want 21", t2); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int spur, lat;
    logic [127:0] e;
    @(negedge clk);
    in_valid = 1'b1; key = K1; plaintext = P1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; key = '0; plaintext = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || cyphertext !== 128'h0 || in_ready !== 1'b1 || lrk !== 128'h0) begin
      errors++; $display("FAIL rst_mid_run got ov=%b busy=%b ir=%b ct=%h want ov=0 busy=0 ir=1 ct=0", out_valid, busy, in_ready, cyphertext);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    spur = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid || busy) spur++; end
    checks++; if (spur !== 0) begin errors++; $display("FAIL rst_no_ghost got %0d active cycles want 0", spur); end
    @(negedge clk);
    in_valid = 1'b1; key = K2; plaintext = P2;
    exp_q.push_back(C2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 10) begin errors++; $display("FAIL rst_after_latency got %0d want 10", lat); end
    e = exp_q.pop_front();
    checks++; if (cyphertext !== e) begin errors++; $display("FAIL rst_after_ct got %h want %h", cyphertext, e); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_input_change();
    int lat;
    logic [127:0] e;
    @(negedge clk);
    in_valid = 1'b1; key = K1; plaintext = P1; out_ready = 1'b1;
    exp_q.push_back(C1);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      key = ~key; plaintext = plaintext ^ {4{32'hdeadbeef}}; in_valid = 1'b1;
      @(posedge clk); #1; lat++;
      if (!out_valid) begin
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL chg_run got ir=%b busy=%b want ir=0 busy=1", in_ready, busy);
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL chg_latency got %0d want 10", lat); end
    e = exp_q.pop_front();
    checks++; if (cyphertext !== e) begin errors++; $display("FAIL chg_ct got %h want %h", cyphertext, e); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL chg_idle got busy=%b ov=%b want busy=0 ov=0", busy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vector_unroll1();
    test_unroll();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_input_change();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
